// File: rtl/audio_pkg.sv
// Shared audio types: scheduler FSM states, sample widths
// and the source-index width helper.
package audio_pkg;

  localparam int STEREO_W = 24;
  localparam int MONO_W   = 16;
  localparam int BEAT_W   = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT_L,
    S_GRANT_R,
    S_WAIT_OUT
  } sched_state_t;

  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after the
// last winner; the pointer moves only on an advance strobe.
module rr_arbiter
  import audio_pkg::*;
#(
  parameter int N = 4,
  parameter int W = src_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_oh
);

  logic [W-1:0] last_ptr;

  // Remember the most recent winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_ptr <= W'(N - 1);
    end else if (advance && gnt_valid) begin
      last_ptr <= gnt_idx;
    end
  end

  // Scan downward so the closest requester after last_ptr wins.
  always_comb begin
    int j;
    j         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_ptr) + k) % N;
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = W'(j);
      end
    end
    if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/mono_mix_scheduler.sv
// Shares one stereo_to_mono converter among N_SRC stereo
// sources, one atomic L/R pair per grant, tagging results.
module mono_mix_scheduler
  import audio_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int FRAME_LEN = 256,
  localparam int SRC_W    = src_w(N_SRC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [32*N_SRC-1:0]   s_axis_data,
  input  logic [N_SRC-1:0]      s_axis_valid,
  output logic [N_SRC-1:0]      s_axis_ready,
  output logic                  conv_resetn,
  output logic [BEAT_W-1:0]     conv_s_axis_data,
  output logic                  conv_s_axis_valid,
  input  logic                  conv_s_axis_ready,
  output logic                  conv_s_axis_last,
  input  logic [MONO_W-1:0]     conv_m_axis_data,
  input  logic                  conv_m_axis_valid,
  output logic                  conv_m_axis_ready,
  output logic [MONO_W-1:0]     m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic [SRC_W-1:0]      m_axis_dest,
  output logic                  busy,
  output logic                  frame_done,
  output logic [SRC_W-1:0]      frame_src
);

  localparam int CNT_W = $clog2(FRAME_LEN);

  sched_state_t state, state_nx;

  logic [SRC_W-1:0] grant;
  logic [N_SRC-1:0] grant_oh;
  logic [CNT_W-1:0] cnt [N_SRC];

  logic             arb_valid;
  logic [SRC_W-1:0] arb_idx;
  logic [N_SRC-1:0] arb_oh;
  logic             advance;
  logic             out_hs;
  logic             out_last;

  rr_arbiter #(
    .N(N_SRC),
    .W(SRC_W)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (s_axis_valid),
    .advance  (advance),
    .gnt_valid(arb_valid),
    .gnt_idx  (arb_idx),
    .gnt_oh   (arb_oh)
  );

  assign conv_resetn = ~reset;
  assign busy        = (state != S_IDLE);
  assign m_axis_dest = grant;
  assign out_last    = (cnt[grant] == CNT_W'(FRAME_LEN - 1));
  assign out_hs      = m_axis_valid & m_axis_ready;

  // Next-state logic and the source/converter/output muxing.
  always_comb begin
    state_nx          = state;
    advance           = 1'b0;
    s_axis_ready      = '0;
    conv_s_axis_data  = '0;
    conv_s_axis_valid = 1'b0;
    conv_s_axis_last  = 1'b0;
    conv_m_axis_ready = 1'b0;
    m_axis_data       = '0;
    m_axis_valid      = 1'b0;
    m_axis_last       = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && arb_valid) begin
          advance  = 1'b1;
          state_nx = S_GRANT_L;
        end
      end
      S_GRANT_L, S_GRANT_R: begin
        conv_s_axis_data  = s_axis_data[BEAT_W*grant +: BEAT_W];
        conv_s_axis_valid = s_axis_valid[grant];
        conv_s_axis_last  = (state == S_GRANT_R);
        s_axis_ready      = grant_oh & {N_SRC{conv_s_axis_ready}};
        if (s_axis_valid[grant] && conv_s_axis_ready) begin
          state_nx = (state == S_GRANT_L) ? S_GRANT_R : S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        m_axis_data       = conv_m_axis_data;
        m_axis_valid      = conv_m_axis_valid;
        m_axis_last       = out_last;
        conv_m_axis_ready = m_axis_ready;
        if (conv_m_axis_valid && m_axis_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (reset) begin
      s_axis_ready      = '0;
      conv_s_axis_valid = 1'b0;
      conv_m_axis_ready = 1'b0;
      m_axis_valid      = 1'b0;
    end
  end

  // State, latched grant, per-source frame counters, frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      grant_oh   <= '0;
      frame_done <= 1'b0;
      frame_src  <= '0;
      for (int i = 0; i < N_SRC; i++) cnt[i] <= '0;
    end else begin
      state      <= state_nx;
      frame_done <= 1'b0;
      if (advance) begin
        grant    <= arb_idx;
        grant_oh <= arb_oh;
      end
      if (out_hs) begin
        cnt[grant] <= out_last ? '0 : cnt[grant] + 1'b1;
        if (out_last) begin
          frame_done <= 1'b1;
          frame_src  <= grant;
        end
      end
    end
  end

endmodule
